multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Main control unit for the multicycle RISC-V core. It sequences the shared-memory datapath (PC, IR, register file, ALU, single unified memory) over multiple cycles per instruction.
- Decodes op/funct fields and drives every datapath select and write enable.
- Counts retired instructions and flags illegal opcodes.
- Sits inside the processor core between the instruction register and the datapath; the top level exposes only memory signals.

Parameters:
CNT_W, 32, width of retired-instruction counter instret.

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high; forces FSM to FETCH and clears instret
op  input  7  instruction opcode, IR[6:0]
funct3  input  3  IR[14:12]
funct7b5  input  1  IR[30]
zero  input  1  ALU zero flag (combinational, current cycle)
PCWrite  output  1  PC register enable = PCUpdate | (Branch & zero)
AdrSrc  output  1  memory address: 0=PC, 1=ALUOut
MemWrite  output  1  memory write enable
IRWrite  output  1  IR/OldPC enable
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1 reg
ALUSrcB  output  2  00=rs2 reg, 01=ImmExt, 10=const 4
ImmSrc  output  2  00=I, 01=S, 10=B, 11=J; decoded from op only
RegWrite  output  1  register-file write enable
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
illegal  output  1  sticky, set on unsupported opcode
instret  output  CNT_W  retired-instruction count

Behaviour:
- Moore FSM, 4-bit state. Unlisted outputs are 0/00. ALUOp is internal: 00 add, 01 sub, 10 funct.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1 -> DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other op -> ERROR
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> MEMREAD if op[5]=0, else MEMWR.
- MEMREAD: ResultSrc=00, AdrSrc=1 -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWR: ResultSrc=00, AdrSrc=1, MemWrite=1 -> FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH. PCWrite follows zero in the same cycle.
- ERROR: all enables 0, illegal=1. Stays in ERROR until reset.
- Cycles per instruction:
  - lw 5
  - sw 4
  - R-type 4
  - I-type 4
  - jal 4
  - beq 3
- ALU decoder (combinational):
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10, by funct3:
    - 000 -> 001 if (op[5] & funct7b5), else 000
    - 010 -> 101
    - 110 -> 011
    - 111 -> 010
    - other funct3 -> 000
- instret increments by 1 on the clock edge leaving MEMWB, MEMWR, ALUWB or BEQ. It wraps modulo 2^CNT_W. JAL counts once, via ALUWB.
- Reset, asynchronous:
  - state=FETCH, instret=0, illegal=0.
  - While reset=1, PCWrite, IRWrite, RegWrite and MemWrite are forced 0; other outputs show FETCH values.
  - Reset mid-instruction (any state, including ERROR) aborts immediately. First FETCH after reset deassertion is on the next posedge.
- op/funct/zero are sampled only in the states that use them. Changes elsewhere have no effect.

Test Plan:
- Reset at time 0, released after 22 ns with op=0000011 -> cycle 1 FETCH (IRWrite=1, PCWrite=1); cycles 2-5 DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; instret=1 after cycle 5.
- sw (op=0100011) -> MemWrite=1 and AdrSrc=1 in exactly the 4th cycle; PCWrite=1 only in FETCH; RegWrite never asserted; instret increments by 1.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in EXECR. Same with funct7b5=0 -> 000. funct3=010 -> 101. I-type addi with funct7b5=1 -> 000.
- beq with zero=1 -> PCWrite=1 in 3rd cycle. Same with zero=0 -> PCWrite=0. Both take 3 cycles and increment instret.
- jal (op=1101111) -> PCWrite=1 in FETCH and JAL, RegWrite=1 in ALUWB, 4 cycles total.
- op=0000000 -> ERROR after DECODE; illegal=1 and all enables 0 for 10+ cycles. Reset asserted mid-MEMREAD of a later lw -> state=FETCH immediately, instret=0, illegal=0, no RegWrite pulse.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the shared-memory RISC-V datapath, with ALU/imm decode, retire counter and illegal flag
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic [2:0]       ALUControl,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);
  typedef enum logic [3:0] {
    s_fetch, s_decode, s_memadr, s_memread, s_memwb, s_memwr,
    s_execr, s_execi, s_aluwb, s_jal, s_beq, s_error
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011;
  state_t state;
  logic [1:0] aluop;
  logic legal, pcupdate, branch;
  assign legal = op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= s_fetch;
      instret <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        s_fetch:                   state <= s_decode;
        s_decode:                  state <= (op == OP_LW || op == OP_SW) ? s_memadr :
                                            op == OP_R   ? s_execr :
                                            op == OP_I   ? s_execi :
                                            op == OP_JAL ? s_jal   :
                                            op == OP_BEQ ? s_beq   : s_error;
        s_memadr:                  state <= op[5] ? s_memwr : s_memread;
        s_memread:                 state <= s_memwb;
        s_execr, s_execi, s_jal:   state <= s_aluwb;
        s_error:                   state <= s_error;
        default:                   state <= s_fetch;
      endcase
      if (state == s_decode && !legal) illegal <= 1'b1;
      if (state inside {s_memwb, s_memwr, s_aluwb, s_beq}) instret <= instret + CNT_W'(1);
    end
  end
  // enables are gated by reset so nothing is written while the core is held
  assign pcupdate   = state inside {s_fetch, s_jal};
  assign branch     = state == s_beq;
  assign PCWrite    = ~reset & (pcupdate | (branch & zero));
  assign IRWrite    = ~reset & (state == s_fetch);
  assign MemWrite   = ~reset & (state == s_memwr);
  assign RegWrite   = ~reset & (state inside {s_memwb, s_aluwb});
  assign AdrSrc     = state inside {s_memread, s_memwr};
  assign ResultSrc  = state == s_fetch ? 2'b10 : state == s_memwb ? 2'b01 : 2'b00;
  assign ALUSrcA    = state inside {s_decode, s_jal} ? 2'b01 :
                      state inside {s_memadr, s_execr, s_execi, s_beq} ? 2'b10 : 2'b00;
  assign ALUSrcB    = state inside {s_fetch, s_jal} ? 2'b10 :
                      state inside {s_decode, s_memadr, s_execi} ? 2'b01 : 2'b00;
  assign aluop      = state inside {s_execr, s_execi} ? 2'b10 : state == s_beq ? 2'b01 : 2'b00;
  assign ImmSrc     = op == OP_SW ? 2'b01 : op == OP_BEQ ? 2'b10 : op == OP_JAL ? 2'b11 : 2'b00;
  assign ALUControl = aluop == 2'b00 ? 3'b000 :
                      aluop == 2'b01 ? 3'b001 :
                      funct3 == 3'b000 ? {2'b00, op[5] & funct7b5} :
                      funct3 == 3'b010 ? 3'b101 :
                      funct3 == 3'b110 ? 3'b011 :
                      funct3 == 3'b111 ? 3'b010 : 3'b000;
endmodule
